// File: rtl/top_adder_pkg.sv
// Shared constants for the rca_adder design; every block and bench imports
// the operand width from here instead of redefining it.
package top_adder_pkg;

  localparam int NBIT_DEFAULT = 8;

endpackage : top_adder_pkg

// File: rtl/top_adder_full_adder.sv
// Single full-adder cell: one link of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/top_adder.sv
// Unsigned NBIT-bit ripple-carry adder with a registered sum; the carry out
// of the MSB is dropped, so S is (A + B) mod 2^NBIT one cycle later.
module top_adder
  import top_adder_pkg::*;
#(
  parameter int NBIT = NBIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBIT-1:0] A,
  input  logic [NBIT-1:0] B,
  output logic [NBIT-1:0] S
);

  logic [NBIT-1:0] w_sum;
  logic            w_unused_carry;
  logic [NBIT-1:0] r_sum;

  // Each stage owns its carry nets so the chain is a plain linear path.
  for (genvar i = 0; i < NBIT; i++) begin : g_fa
    logic w_cin;
    logic w_cout;

    if (i == 0) begin : g_first
      assign w_cin = 1'b0;
    end else begin : g_rest
      assign w_cin = g_fa[i-1].w_cout;
    end

    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (w_cin),
      .s    (w_sum[i]),
      .cout (w_cout)
    );
  end

  assign w_unused_carry = g_fa[NBIT-1].w_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum;
    end
  end

  assign S = r_sum;

endmodule : top_adder

// File: tb/tb_top_adder.sv
// Bench for top_adder: an 8-bit instance checked every cycle against an
// arithmetic reference, plus a 1-bit instance for the narrowest legal width.
module tb_top_adder;
  import top_adder_pkg::*;

  localparam int W = NBIT_DEFAULT;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] S;
  logic [0:0]   A1;
  logic [0:0]   B1;
  logic [0:0]   S1;

  int checks;
  int passes;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_s;

  top_adder #(.NBIT(W)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .S   (S)
  );

  top_adder #(.NBIT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .A   (A1),
    .B   (B1),
    .S   (S1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // reference model: the sum sampled at each rising edge, mod 2^W
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.push_back(W'((int'(A) + int'(B)) % (1 << W)));
    end
  end

  always @(posedge rst) begin
    exp_q.delete();
    model_s = '0;
  end

  // single compare process, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_s = '0;
      check("reset_hold", int'(S), 0);
    end else begin
      if (exp_q.size() > 0) model_s = exp_q.pop_front();
      check("model_sum", int'(S), int'(model_s));
    end
  end

  // driver tasks
  task automatic drive(input int a, input int b);
    @(posedge clk);
    #1;
    A = W'(a);
    B = W'(b);
  endtask

  task automatic vec(input string name, input int a, input int b, input int exp);
    drive(a, b);
    @(posedge clk);
    #1;
    check(name, int'(S), exp);
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
    model_s = '0;
    rst = 1'b0;
    A   = W'(2);
    B   = W'(3);
    A1  = 1'b0;
    B1  = 1'b0;

    // reset clears S without a clock edge
    #1 rst = 1'b1;
    #1 check("reset_async", int'(S), 0);
    check("reset_async_w1", int'(S1), 0);
    repeat (2) begin
      @(posedge clk);
      #1 check("reset_across_edge", int'(S), 0);
    end
    #1 rst = 1'b0;
    #1 check("reset_release_hold", int'(S), 0);
    @(posedge clk);
    #1 check("first_after_reset", int'(S), 5);

    // basic sums
    vec("sum_0_0", 0, 0, 0);
    vec("sum_2_0", 2, 0, 2);
    vec("sum_2_3", 2, 3, 5);
    vec("sum_7_3", 7, 3, 10);
    vec("sum_7_8", 7, 8, 15);

    // carry ripple and wrap
    vec("wrap_255_1", 255, 1, 0);
    vec("wrap_200_100", 200, 100, 44);
    vec("ripple_127_1", 127, 1, 128);
    vec("wrap_255_255", 255, 255, 254);

    // mid-cycle input change waits for the next edge
    vec("latency_7_8", 7, 8, 15);
    #3 A = W'(9);
    #1 check("hold_mid_cycle", int'(S), 15);
    @(posedge clk);
    #1 check("latency_9_8", int'(S), 17);

    // static inputs keep S constant
    drive(100, 50);
    repeat (5) begin
      @(posedge clk);
      #1 check("static_hold", int'(S), 150);
    end

    // reset pulse between edges
    #2 rst = 1'b1;
    #1 check("midop_reset", int'(S), 0);
    #1 rst = 1'b0;
    #1 check("midop_reset_release", int'(S), 0);
    @(posedge clk);
    #1 check("midop_reload", int'(S), 150);

    // narrowest width
    @(posedge clk);
    #1 A1 = 1'b0; B1 = 1'b0;
    @(posedge clk);
    #1 check("w1_0_0", int'(S1), 0);
    A1 = 1'b0; B1 = 1'b1;
    @(posedge clk);
    #1 check("w1_0_1", int'(S1), 1);
    A1 = 1'b1; B1 = 1'b1;
    @(posedge clk);
    #1 check("w1_1_1", int'(S1), 0);

    // random pairs, checked by the compare process
    for (int i = 0; i < 10000; i++) begin
      drive(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
    end
    @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_top_adder
